// File: rtl/sel_arbiter_4.sv
// Round-robin arbiter sharing one 4-to-1 selector among four requesters.
// Define SEL_ARB_TIMEOUT_EN to compile in the MAX_HOLD preemption counter.
module sel_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] SEL,
    output logic       VALID
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("sel_arbiter_4: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic               any_req;
    logic               holder_req;
    logic               expire;

`ifdef SEL_ARB_TIMEOUT_EN
    localparam int unsigned HCNT_W = 8;
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

    logic [HCNT_W-1:0]  hcnt;
`endif

    // Search LAST+1, LAST+2, LAST+3, LAST; the holder (== LAST) is always searched last.
    always_comb begin
        win   = last;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'(last + IDX_W'(k));
            if (!found && REQ[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req    = |REQ;
    assign holder_req = REQ[SEL];

`ifdef SEL_ARB_TIMEOUT_EN
    assign expire = (hcnt == HOLD_LAST) && holder_req && (|(REQ & ~GNT));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            last  <= IDX_W'(N_REQ - 1);
            GNT   <= '0;
            SEL   <= '0;
            VALID <= 1'b0;
`ifdef SEL_ARB_TIMEOUT_EN
            hcnt  <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= BUSY;
                        last  <= win;
                        GNT   <= 4'b0001 << win;
                        SEL   <= win;
                        VALID <= 1'b1;
`ifdef SEL_ARB_TIMEOUT_EN
                        hcnt  <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Release takes precedence over expiry; both re-arbitrate the same way.
                    if ((!holder_req && any_req) || expire) begin
                        last  <= win;
                        GNT   <= 4'b0001 << win;
                        SEL   <= win;
                        VALID <= 1'b1;
`ifdef SEL_ARB_TIMEOUT_EN
                        hcnt  <= '0;
`endif
                    end else if (!holder_req) begin
                        state <= IDLE;
                        GNT   <= '0;
                        VALID <= 1'b0;
`ifdef SEL_ARB_TIMEOUT_EN
                        hcnt  <= '0;
`endif
                    end else begin
`ifdef SEL_ARB_TIMEOUT_EN
                        if (hcnt != HOLD_LAST) begin
                            hcnt <= hcnt + HCNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    GNT   <= '0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
